shiftreg_slave: RTL and testbench

// - Responder end of the shiftreg serial expansion link; the FPGA acts as a 74HC165/74HC595-style chain for an external master.
// - Inputs sclk/load/din come from the master and are asynchronous to clk; output dout goes to the master's serial input.
// - Shifts WIDTH bits in and out per frame, then presents the received word in parallel. Used for board-to-board I/O expansion.

---
 rtl/shiftreg_slave_pkg.sv | 22 ++
 rtl/shiftreg_in_sync.sv | 67 ++++++
 rtl/shiftreg_slave.sv | 125 ++++++++++++
 tb/tb_shiftreg_slave.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shiftreg_slave_pkg.sv
// Shared state encoding and sizing helpers for the shiftreg serial-link responder.
package shiftreg_slave_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int SYNC_STAGES = 2;

    // Smallest bit count that can represent value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/shiftreg_in_sync.sv
// Synchronizer and rise/fall pulse generator for one asynchronous link input.
// With SHIFTREG_SLAVE_GLITCH_FILTER_EN defined, a stability filter sits after the synchronizer.
module shiftreg_in_sync
    import shiftreg_slave_pkg::*;
#(
    parameter int   FILTER_LEN = 3,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

`ifdef SHIFTREG_SLAVE_GLITCH_FILTER_EN
    logic [3:0] r_filt_cnt;
    logic       r_filt;

    // A new level is accepted only once it has been seen FILTER_LEN clk in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_cnt <= '0;
            r_filt     <= RST_VAL;
        end else if (r_sync[SYNC_STAGES-1] == r_filt) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == 4'(FILTER_LEN - 1)) begin
            r_filt     <= r_sync[SYNC_STAGES-1];
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 4'd1;
        end
    end

    assign w_level = r_filt;
`else
    localparam int unused_filter_len = FILTER_LEN;

    assign w_level = r_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= RST_VAL;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/shiftreg_slave.sv
// Responder end of the shiftreg serial expansion link (74HC165/74HC595-style chain).
// Optional input glitch filter: define SHIFTREG_SLAVE_GLITCH_FILTER_EN.
module shiftreg_slave
    import shiftreg_slave_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FILTER_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             load,
    input  logic             din,
    output logic             dout,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_err
);

    localparam int               CNT_W    = clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_load_lvl, w_load_rise, w_load_fall;
    logic w_din_lvl, w_din_rise, w_din_fall;
    logic w_unused;

    state_t           r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_rx_shift;
    logic [WIDTH-1:0] r_tx_shift;
    logic             r_dout;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;

    shiftreg_in_sync #(.FILTER_LEN(FILTER_LEN), .RST_VAL(1'b0)) u_sclk_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (sclk),
        .o_level (w_sclk_lvl),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    // load resets high so a frame already in progress at reset release is
    // not mistaken for a new frame start; it must drop and rise again.
    shiftreg_in_sync #(.FILTER_LEN(FILTER_LEN), .RST_VAL(1'b1)) u_load_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (load),
        .o_level (w_load_lvl),
        .o_rise  (w_load_rise),
        .o_fall  (w_load_fall)
    );

    shiftreg_in_sync #(.FILTER_LEN(FILTER_LEN), .RST_VAL(1'b0)) u_din_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (din),
        .o_level (w_din_lvl),
        .o_rise  (w_din_rise),
        .o_fall  (w_din_fall)
    );

    assign w_unused = &{1'b0, w_sclk_lvl, w_sclk_fall, w_din_rise, w_din_fall};

    // r_dout is loaded with the same value as the next r_tx_shift[0], so the
    // first bit appears without an extra register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SYNC;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_dout      <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                SYNC: begin
                    if (w_load_rise) begin
                        r_tx_shift <= tx_data;
                        r_dout     <= tx_data[0];
                        r_bit_cnt  <= '0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_load_fall) begin
                        r_state <= LATCH;
                    end else if (w_sclk_rise && w_load_lvl) begin
                        r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_din_lvl};
                        r_tx_shift <= {1'b0, r_tx_shift[WIDTH-1:1]};
                        r_dout     <= r_tx_shift[1];
                        if (r_bit_cnt != CNT_SAT) begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end
                LATCH: begin
                    if (r_bit_cnt == CNT_FULL) begin
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                    r_state <= SYNC;
                end
                default: r_state <= SYNC;
            endcase
        end
    end

    assign dout      = r_dout;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_shiftreg_slave.sv
// Directed bench for shiftreg_slave: a master model drives frames and checks rx/tx words and pulses.
`timescale 1ns/1ps
module tb_shiftreg_slave;

    localparam int WIDTH = 8;
    localparam int HALF  = 20;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             sclk    = 1'b0;
    logic             load    = 1'b0;
    logic             din     = 1'b0;
    logic [WIDTH-1:0] tx_data = '0;
    logic             dout;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             frame_err;

    int vectors = 0;
    int errors  = 0;
    int n_valid = 0;
    int n_err   = 0;

    shiftreg_slave #(.WIDTH(WIDTH), .FILTER_LEN(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .load      (load),
        .din       (din),
        .dout      (dout),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) n_valid++;
        if (frame_err === 1'b1) n_err++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master model: raise load, optional extra sclk pulse of pre_clk clk with din=1,
    // then nbits MSB-first data bits; dout is captured just before each sclk rise.
    task automatic master_frame(input logic [7:0] word, input int nbits, input int pre_clk,
                                output logic [7:0] cap);
        cap  = '0;
        load = 1'b1;
        wait_clk(HALF);
        if (pre_clk > 0) begin
            din = 1'b1;
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(pre_clk);
            sclk = 1'b0;
            wait_clk(HALF);
        end
        for (int i = 0; i < nbits; i++) begin
            din = (i < 8) ? word[7-i] : 1'b0;
            wait_clk(HALF);
            if (i < 8) cap[i] = dout;
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        load = 1'b0;
        wait_clk(12);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clk(3);
        vectors++;
        if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b expected 0", dout); end
        vectors++;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        vectors++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        vectors++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        rst_n = 1'b1;
        wait_clk(5);
    endtask

    task automatic test_single_frame();
        logic [7:0] cap;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        tx_data = 8'h3C;
        master_frame(8'hA5, 8, 0, cap);
        vectors++;
        if (rx_data !== 8'hA5) begin errors++; $display("FAIL t1_rx_data: got %h expected a5", rx_data); end
        vectors++;
        if (n_valid - v0 !== 1) begin errors++; $display("FAIL t1_rx_valid_pulses: got %0d expected 1", n_valid - v0); end
        vectors++;
        if (n_err - e0 !== 0) begin errors++; $display("FAIL t1_frame_err_pulses: got %0d expected 0", n_err - e0); end
        vectors++;
        if (cap !== 8'h3C) begin errors++; $display("FAIL t1_master_capture: got %h expected 3c", cap); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] cap;
        int v0;
        v0 = n_valid;
        tx_data = 8'hFF;
        master_frame(8'h01, 8, 0, cap);
        vectors++;
        if (rx_data !== 8'h01) begin errors++; $display("FAIL t2_rx_data_a: got %h expected 01", rx_data); end
        vectors++;
        if (cap !== 8'hFF) begin errors++; $display("FAIL t2_dout_ones: got %h expected ff", cap); end
        tx_data = 8'h00;
        master_frame(8'h80, 8, 0, cap);
        vectors++;
        if (rx_data !== 8'h80) begin errors++; $display("FAIL t2_rx_data_b: got %h expected 80", rx_data); end
        vectors++;
        if (cap !== 8'h00) begin errors++; $display("FAIL t2_dout_zeros: got %h expected 00", cap); end
        vectors++;
        if (n_valid - v0 !== 2) begin errors++; $display("FAIL t2_rx_valid_pulses: got %0d expected 2", n_valid - v0); end
    endtask

    task automatic test_short_frame();
        logic [7:0] cap;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        tx_data = 8'h00;
        master_frame(8'h55, 7, 0, cap);
        vectors++;
        if (rx_data !== 8'h80) begin errors++; $display("FAIL t3_rx_data_held: got %h expected 80", rx_data); end
        vectors++;
        if (n_err - e0 !== 1) begin errors++; $display("FAIL t3_frame_err_pulses: got %0d expected 1", n_err - e0); end
        vectors++;
        if (n_valid - v0 !== 0) begin errors++; $display("FAIL t3_rx_valid_pulses: got %0d expected 0", n_valid - v0); end
    endtask

    task automatic test_long_frame();
        logic [7:0] cap;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        master_frame(8'hAA, 9, 0, cap);
        vectors++;
        if (n_err - e0 !== 1) begin errors++; $display("FAIL t4_frame_err_pulses: got %0d expected 1", n_err - e0); end
        vectors++;
        if (n_valid - v0 !== 0) begin errors++; $display("FAIL t4_rx_valid_pulses: got %0d expected 0", n_valid - v0); end
        vectors++;
        if (rx_data !== 8'h80) begin errors++; $display("FAIL t4_rx_data_held: got %h expected 80", rx_data); end
        tx_data = 8'h5A;
        master_frame(8'hC3, 8, 0, cap);
        vectors++;
        if (rx_data !== 8'hC3) begin errors++; $display("FAIL t4_recover_rx_data: got %h expected c3", rx_data); end
        vectors++;
        if (cap !== 8'h5A) begin errors++; $display("FAIL t4_recover_capture: got %h expected 5a", cap); end
        vectors++;
        if (n_valid - v0 !== 1) begin errors++; $display("FAIL t4_recover_valid: got %0d expected 1", n_valid - v0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] cap;
        logic [7:0] word;
        int v0, e0;
        word = 8'hF0;
        tx_data = 8'hFF;
        load = 1'b1;
        wait_clk(HALF);
        for (int i = 0; i < 4; i++) begin
            din = word[7-i];
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        rst_n = 1'b0;
        wait_clk(2);
        vectors++;
        if (dout !== 1'b0) begin errors++; $display("FAIL t5_reset_dout: got %b expected 0", dout); end
        vectors++;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL t5_reset_rx_data: got %h expected 00", rx_data); end
        vectors++;
        if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL t5_reset_pulses: got valid=%b err=%b expected 0 0", rx_valid, frame_err);
        end
        rst_n = 1'b1;
        wait_clk(2);
        v0 = n_valid; e0 = n_err;
        for (int i = 4; i < 8; i++) begin
            din = word[7-i];
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        load = 1'b0;
        wait_clk(12);
        vectors++;
        if (n_valid - v0 !== 0 || n_err - e0 !== 0) begin
            errors++;
            $display("FAIL t5_tail_ignored: got valid=%0d err=%0d expected 0 0", n_valid - v0, n_err - e0);
        end
        vectors++;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL t5_tail_rx_data: got %h expected 00", rx_data); end
        tx_data = 8'hE1;
        master_frame(8'h96, 8, 0, cap);
        vectors++;
        if (rx_data !== 8'h96) begin errors++; $display("FAIL t5_next_rx_data: got %h expected 96", rx_data); end
        vectors++;
        if (cap !== 8'hE1) begin errors++; $display("FAIL t5_next_capture: got %h expected e1", cap); end
    endtask

`ifdef SHIFTREG_SLAVE_GLITCH_FILTER_EN
    task automatic test_glitch_filter();
        logic [7:0] cap;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        tx_data = 8'h00;
        master_frame(8'h3A, 8, 2, cap);
        vectors++;
        if (rx_data !== 8'h3A) begin errors++; $display("FAIL t6_glitch_rx_data: got %h expected 3a", rx_data); end
        vectors++;
        if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin
            errors++;
            $display("FAIL t6_glitch_pulses: got valid=%0d err=%0d expected 1 0", n_valid - v0, n_err - e0);
        end
        v0 = n_valid; e0 = n_err;
        master_frame(8'h25, 7, 4, cap);
        vectors++;
        if (rx_data !== 8'h92) begin errors++; $display("FAIL t6_pulse_rx_data: got %h expected 92", rx_data); end
        vectors++;
        if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin
            errors++;
            $display("FAIL t6_pulse_pulses: got valid=%0d err=%0d expected 1 0", n_valid - v0, n_err - e0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_short_frame();
        test_long_frame();
        test_reset_mid_frame();
`ifdef SHIFTREG_SLAVE_GLITCH_FILTER_EN
        test_glitch_filter();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
